branch_predictor_gshare: RTL and testbench
==========================================

Name: branch_predictor_gshare

Overview:
- Parametrised successor to the core's 1-bit, PC-indexed BHT.
- Pattern history table (PHT) of saturating counters, selectable bimodal or gshare indexing, global history register (GHR), power-on table-clear sequencer and hit/branch statistics counters.
- Decode stage queries it combinationally with fd_PC. Execute stage resolves branches and writes back the outcome through the index that was carried down the pipe.

Parameters:
- IDX_BITS, 4: log2 of PHT entries; SIZE = 1<<IDX_BITS.
- CTR_BITS, 2: counter width, 1..3. CTR_BITS=1 reproduces the legacy 1-bit BHT exactly.
- HIST_BITS, 4: GHR width, 1..IDX_BITS.
- GSHARE, 1: 1 = index is PC bits XOR GHR; 0 = bimodal, PC bits only.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high once the table-clear sweep has completed.
- pred_pc  in  32  PC of the instruction in decode (fd_PC).
- pred_taken  out  1  predicted direction, combinational.
- pred_index  out  IDX_BITS  PHT index used for this prediction; the core carries it to execute.
- upd_valid  in  1  a conditional branch resolves in execute this cycle.
- upd_index  in  IDX_BITS  carried pred_index of the resolving branch.
- upd_taken  in  1  actual outcome (e_takeB).
- upd_predicted  in  1  carried pred_taken, used for statistics only.
- nb_branch  out  32  resolved-branch count, saturating.
- nb_hit  out  32  correctly predicted branch count, saturating.

Behaviour:
- Index computation:
  - base = pred_pc[IDX_BITS+1:2].
  - GSHARE=1: pred_index = base ^ {{(IDX_BITS-HIST_BITS){1'b0}}, ghr}.
  - GSHARE=0: pred_index = base.
- Prediction:
  - pred_taken = ready & PHT[pred_index][CTR_BITS-1]. This is a purely combinational read of the registered table and GHR.
  - Forced 0 while ready is low.
- FSM states:
  - INIT: sweep counter clr_idx writes PHT[clr_idx] = WNT, where WNT = (1<<(CTR_BITS-1))-1 (2'b01 for CTR_BITS=2, 0 for CTR_BITS=1). clr_idx increments each cycle. Moves to RUN after the write at SIZE-1, so INIT lasts exactly SIZE cycles.
  - RUN: normal operation; ready=1 from the first RUN cycle.
- Reset (any cycle, including mid-sweep or mid-run):
  - state=INIT, clr_idx=0, ghr=0, nb_branch=0, nb_hit=0.
  - ready=0 and pred_taken=0 in the cycle after reset is sampled.
  - PHT contents are not reset directly; the sweep rewrites every entry.
- Update (RUN only; upd_valid in INIT is ignored entirely):
  - PHT[upd_index] increments if upd_taken, else decrements, saturating at 0 and (1<<CTR_BITS)-1.
  - ghr <= {ghr[HIST_BITS-2:0], upd_taken}, or ghr <= upd_taken when HIST_BITS=1.
  - nb_branch += 1 unless already 32'hFFFFFFFF.
  - nb_hit += 1 when upd_predicted == upd_taken, unless saturated.
- Update is non-speculative: the GHR advances only at resolve. A prediction made in the same cycle as an update sees the pre-update GHR and counter (read-before-write).
- Same-index collision: pred_index == upd_index in the same cycle makes pred_taken reflect the old counter value. No bypass.
- Only one update per cycle. Latency from update to visible prediction is 1 cycle.
- No stall input: the core holds pred_pc stable during decode stalls. A stable pred_pc yields a stable output unless an update lands.

Test Plan:
- Sweep: assert reset 1 cycle with IDX_BITS=4. ready stays 0 for 16 cycles, rises on cycle 17; every PHT entry reads 2'b01 and pred_taken=0 for all PCs.
- Saturation: GSHARE=0, pred_pc=0x40 (index 0). Two taken updates make pred_taken=1 (counter 11). A third taken update keeps the counter at 11. One not-taken update gives 10, still taken. A second gives 01, pred_taken=0.
- Gshare aliasing: GSHARE=1 at 0x40. After the taken,taken,not-taken,taken sequence ghr=4'b1101 and pred_index=0x0^0xD=0xD; the bimodal build gives 0x0.
- Collision: in the same cycle, update index 3 with taken (counter 01) and predict PC 0x0C. pred_taken=0 that cycle and 1 the next.
- Mid-sweep reset: reset at sweep cycle 7. Sweep restarts at 0, ready rises 16 cycles later, and upd_valid pulses during INIT change nothing (nb_branch=0).
- Legacy equivalence and stats: CTR_BITS=1, GSHARE=0. The taken/not-taken stream T,T,N,T on one PC predicts 0,1,1,0. nb_branch=4, nb_hit=1.

Source files
------------

// File: rtl/branch_predictor_gshare_if.sv
// Predictor <-> core bundle: decode-stage query, execute-stage resolve and
// the statistics counters. The core side is the master, the predictor the slave.
interface branch_predictor_gshare_if #(
    parameter int IDX_BITS = 4
);
    logic                ready;
    logic [31:0]         pred_pc;
    logic                pred_taken;
    logic [IDX_BITS-1:0] pred_index;
    logic                upd_valid;
    logic [IDX_BITS-1:0] upd_index;
    logic                upd_taken;
    logic                upd_predicted;
    logic [31:0]         nb_branch;
    logic [31:0]         nb_hit;

    modport master (
        input  ready, pred_taken, pred_index, nb_branch, nb_hit,
        output pred_pc, upd_valid, upd_index, upd_taken, upd_predicted
    );

    modport slave (
        output ready, pred_taken, pred_index, nb_branch, nb_hit,
        input  pred_pc, upd_valid, upd_index, upd_taken, upd_predicted
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare / bimodal branch predictor: a table of saturating counters indexed by
// PC bits (optionally XORed with a global history register), cleared by a
// sweep after reset, with saturating resolved-branch and hit statistics.
module branch_predictor_gshare #(
    parameter int IDX_BITS  = 4,
    parameter int CTR_BITS  = 2,
    parameter int HIST_BITS = 4,
    parameter int GSHARE    = 1
) (
    input  logic clk,
    input  logic reset,
    branch_predictor_gshare_if.slave bp
);
    localparam int                  SIZE    = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] WNT     = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [IDX_BITS-1:0] LAST    = IDX_BITS'(SIZE - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] clr_idx_q, clr_idx_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         nb_branch_q, nb_branch_d;
    logic [31:0]         nb_hit_q, nb_hit_d;
    logic [CTR_BITS-1:0] pht_q [SIZE];

    logic                pht_we;
    logic [IDX_BITS-1:0] pht_waddr;
    logic [CTR_BITS-1:0] pht_wdata;
    logic [CTR_BITS-1:0] upd_ctr;
    logic [IDX_BITS-1:0] base_idx;
    logic                unused_pc_bits;

    assign base_idx       = bp.pred_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{bp.pred_pc[31:IDX_BITS+2], bp.pred_pc[1:0]};

    // Prediction path: read of the registered table and GHR, no bypass from
    // an update landing in the same cycle.
    always_comb begin
        bp.pred_index = base_idx;
        if (GSHARE != 0) begin
            bp.pred_index = base_idx ^ IDX_BITS'(ghr_q);
        end
    end

    assign bp.ready      = (state_q == RUN);
    assign bp.pred_taken = bp.ready & pht_q[bp.pred_index][CTR_BITS-1];
    assign bp.nb_branch  = nb_branch_q;
    assign bp.nb_hit     = nb_hit_q;

    // Next state: clear sweep in INIT, counter/GHR/statistics update in RUN.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        ghr_d       = ghr_q;
        nb_branch_d = nb_branch_q;
        nb_hit_d    = nb_hit_q;
        pht_we      = 1'b0;
        pht_waddr   = clr_idx_q;
        pht_wdata   = WNT;
        upd_ctr     = pht_q[bp.upd_index];

        case (state_q)
            INIT: begin
                pht_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bp.upd_valid) begin
                    pht_we    = 1'b1;
                    pht_waddr = bp.upd_index;
                    if (bp.upd_taken) begin
                        pht_wdata = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + 1'b1;
                    end else begin
                        pht_wdata = (upd_ctr == '0) ? upd_ctr : upd_ctr - 1'b1;
                    end
                    // Shift the outcome in; truncation drops the oldest bit.
                    ghr_d = HIST_BITS'({ghr_q, bp.upd_taken});
                    if (nb_branch_q != '1) begin
                        nb_branch_d = nb_branch_q + 32'd1;
                    end
                    if ((bp.upd_predicted == bp.upd_taken) && (nb_hit_q != '1)) begin
                        nb_hit_d = nb_hit_q + 32'd1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Control and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= INIT;
            clr_idx_q   <= '0;
            ghr_q       <= '0;
            nb_branch_q <= '0;
            nb_hit_q    <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            ghr_q       <= ghr_d;
            nb_branch_q <= nb_branch_d;
            nb_hit_q    <= nb_hit_d;
        end
    end

    // Counter table write port, shared by the clear sweep and the resolve update.
    always_ff @(posedge clk) begin
        // NOTE: the table has no reset branch; the INIT sweep rewrites every entry, keeping it a plain RAM.
        if (pht_we && !reset) begin
            pht_q[pht_waddr] <= pht_wdata;
        end
    end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Scoreboard bench for branch_predictor_gshare: three builds (gshare 2-bit,
// bimodal 2-bit, bimodal 1-bit legacy) driven by directed vectors.
module tb_branch_predictor_gshare;
    typedef enum int {F_READY, F_TAKEN, F_INDEX, F_NB_BRANCH, F_NB_HIT} field_e;

    typedef struct {
        int          dut;
        field_e      field;
        logic [31:0] exp;
        string       name;
    } exp_t;

    localparam int D_GS = 0;
    localparam int D_BM = 1;
    localparam int D_LG = 2;

    logic clk = 1'b0;
    logic rst_gs, rst_bm, rst_lg;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    branch_predictor_gshare_if #(.IDX_BITS(4)) bp_gs ();
    branch_predictor_gshare_if #(.IDX_BITS(4)) bp_bm ();
    branch_predictor_gshare_if #(.IDX_BITS(4)) bp_lg ();

    branch_predictor_gshare #(.IDX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .GSHARE(1))
        u_gs (.clk(clk), .reset(rst_gs), .bp(bp_gs));
    branch_predictor_gshare #(.IDX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .GSHARE(0))
        u_bm (.clk(clk), .reset(rst_bm), .bp(bp_bm));
    branch_predictor_gshare #(.IDX_BITS(4), .CTR_BITS(1), .HIST_BITS(4), .GSHARE(0))
        u_lg (.clk(clk), .reset(rst_lg), .bp(bp_lg));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rst(input int d, input logic r);
        case (d)
            D_GS:    rst_gs = r;
            D_BM:    rst_bm = r;
            default: rst_lg = r;
        endcase
    endtask

    task automatic drive_pc(input int d, input logic [31:0] pc);
        case (d)
            D_GS:    bp_gs.pred_pc = pc;
            D_BM:    bp_bm.pred_pc = pc;
            default: bp_lg.pred_pc = pc;
        endcase
    endtask

    task automatic drive_upd(input int d, input logic v, input logic [3:0] idx,
                             input logic t, input logic p);
        case (d)
            D_GS: begin
                bp_gs.upd_valid = v; bp_gs.upd_index = idx;
                bp_gs.upd_taken = t; bp_gs.upd_predicted = p;
            end
            D_BM: begin
                bp_bm.upd_valid = v; bp_bm.upd_index = idx;
                bp_bm.upd_taken = t; bp_bm.upd_predicted = p;
            end
            default: begin
                bp_lg.upd_valid = v; bp_lg.upd_index = idx;
                bp_lg.upd_taken = t; bp_lg.upd_predicted = p;
            end
        endcase
    endtask

    task automatic expect_val(input int d, input field_e f, input logic [31:0] v,
                              input string name);
        exp_t e;
        e.dut = d; e.field = f; e.exp = v; e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] get_actual(input int d, input field_e f);
        logic [31:0] r;
        r = 'x;
        case (d)
            D_GS: case (f)
                F_READY:     r = 32'(bp_gs.ready);
                F_TAKEN:     r = 32'(bp_gs.pred_taken);
                F_INDEX:     r = 32'(bp_gs.pred_index);
                F_NB_BRANCH: r = bp_gs.nb_branch;
                default:     r = bp_gs.nb_hit;
            endcase
            D_BM: case (f)
                F_READY:     r = 32'(bp_bm.ready);
                F_TAKEN:     r = 32'(bp_bm.pred_taken);
                F_INDEX:     r = 32'(bp_bm.pred_index);
                F_NB_BRANCH: r = bp_bm.nb_branch;
                default:     r = bp_bm.nb_hit;
            endcase
            default: case (f)
                F_READY:     r = 32'(bp_lg.ready);
                F_TAKEN:     r = 32'(bp_lg.pred_taken);
                F_INDEX:     r = 32'(bp_lg.pred_index);
                F_NB_BRANCH: r = bp_lg.nb_branch;
                default:     r = bp_lg.nb_hit;
            endcase
        endcase
        return r;
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = get_actual(e.dut, e.field);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic        sat_t[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        sat_p[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0]  gs_idx[4] = '{4'h0, 4'h1, 4'h3, 4'h6};
        logic        gs_t[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] rb_pc[3]  = '{32'h34, 32'h38, 32'h30};
        logic [3:0]  rb_idx[3] = '{4'h0, 4'h3, 4'h1};
        logic        rb_tk[3]  = '{1'b1, 1'b0, 1'b1};
        logic        lg_t[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        lg_p[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};

        for (int d = 0; d < 3; d++) begin
            set_rst(d, 1'b1);
            drive_pc(d, 32'h0);
            drive_upd(d, 1'b0, 4'h0, 1'b0, 1'b0);
        end

        // Power-on sweep: ready low for 16 cycles, high on the 17th.
        tick();
        for (int d = 0; d < 3; d++) set_rst(d, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            expect_val(D_BM, F_READY, 0, $sformatf("sweep_ready_c%0d", k));
            expect_val(D_BM, F_TAKEN, 0, $sformatf("sweep_taken_c%0d", k));
            if (k == 1) begin
                expect_val(D_GS, F_READY, 0, "gs_ready_after_reset");
                expect_val(D_LG, F_READY, 0, "lg_ready_after_reset");
            end
            tick();
        end
        expect_val(D_BM, F_READY, 1, "sweep_ready_c17");
        expect_val(D_GS, F_READY, 1, "gs_ready_c17");
        expect_val(D_LG, F_READY, 1, "lg_ready_c17");
        expect_val(D_BM, F_NB_BRANCH, 0, "reset_nb_branch");
        expect_val(D_BM, F_NB_HIT, 0, "reset_nb_hit");
        expect_val(D_GS, F_INDEX, 0, "gs_index_ghr0");
        tick();
        for (int i = 0; i < 16; i++) begin
            drive_pc(D_BM, 32'(i) << 2);
            expect_val(D_BM, F_INDEX, 32'(i), $sformatf("cleared_index_%0d", i));
            expect_val(D_BM, F_TAKEN, 0, $sformatf("cleared_taken_%0d", i));
            tick();
        end

        // Saturation on bimodal index 0.
        drive_pc(D_BM, 32'h40);
        for (int i = 0; i < 5; i++) begin
            drive_upd(D_BM, 1'b1, 4'h0, sat_t[i], sat_p[i]);
            expect_val(D_BM, F_TAKEN, 32'(sat_p[i]), $sformatf("sat_taken_%0d", i));
            tick();
        end
        drive_upd(D_BM, 1'b0, 4'h0, 1'b0, 1'b0);
        expect_val(D_BM, F_TAKEN, 0, "sat_taken_final");
        expect_val(D_BM, F_NB_BRANCH, 5, "sat_nb_branch");
        expect_val(D_BM, F_NB_HIT, 2, "sat_nb_hit");
        tick();

        // Gshare history: T,T,N,T drives ghr to 4'b1101.
        drive_pc(D_GS, 32'h40);
        for (int i = 0; i < 4; i++) begin
            drive_upd(D_GS, 1'b1, gs_idx[i], gs_t[i], 1'b0);
            expect_val(D_GS, F_INDEX, 32'(gs_idx[i]), $sformatf("gs_index_%0d", i));
            expect_val(D_GS, F_TAKEN, 0, $sformatf("gs_taken_%0d", i));
            tick();
        end
        drive_upd(D_GS, 1'b0, 4'h0, 1'b0, 1'b0);
        expect_val(D_GS, F_INDEX, 32'hD, "gs_index_ghr_1101");
        expect_val(D_BM, F_INDEX, 32'h0, "bm_index_0x40");
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_pc(D_GS, rb_pc[i]);
            expect_val(D_GS, F_INDEX, 32'(rb_idx[i]), $sformatf("gs_rb_index_%0d", i));
            expect_val(D_GS, F_TAKEN, 32'(rb_tk[i]), $sformatf("gs_rb_taken_%0d", i));
            tick();
        end

        // Same-index collision: old counter seen this cycle, new one next cycle.
        drive_pc(D_BM, 32'h0C);
        drive_upd(D_BM, 1'b1, 4'h3, 1'b1, 1'b0);
        expect_val(D_BM, F_INDEX, 3, "coll_index");
        expect_val(D_BM, F_TAKEN, 0, "coll_taken_same_cycle");
        tick();
        drive_upd(D_BM, 1'b0, 4'h0, 1'b0, 1'b0);
        expect_val(D_BM, F_TAKEN, 1, "coll_taken_next_cycle");
        tick();

        // Mid-sweep reset, with updates offered throughout INIT.
        set_rst(D_BM, 1'b1);
        tick();
        set_rst(D_BM, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            expect_val(D_BM, F_READY, 0, $sformatf("mid_first_ready_c%0d", k));
            tick();
        end
        set_rst(D_BM, 1'b1);
        tick();
        set_rst(D_BM, 1'b0);
        drive_pc(D_BM, 32'h40);
        drive_upd(D_BM, 1'b1, 4'h0, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            expect_val(D_BM, F_READY, 0, $sformatf("mid_ready_c%0d", k));
            expect_val(D_BM, F_TAKEN, 0, $sformatf("mid_taken_c%0d", k));
            tick();
        end
        drive_upd(D_BM, 1'b0, 4'h0, 1'b0, 1'b0);
        expect_val(D_BM, F_READY, 1, "mid_ready_c17");
        expect_val(D_BM, F_TAKEN, 0, "mid_idx0_cleared");
        expect_val(D_BM, F_NB_BRANCH, 0, "mid_nb_branch");
        expect_val(D_BM, F_NB_HIT, 0, "mid_nb_hit");
        tick();
        drive_pc(D_BM, 32'h0C);
        expect_val(D_BM, F_TAKEN, 0, "mid_idx3_cleared");
        tick();

        // Legacy 1-bit: T,T,N,T predicts 0,1,1,0.
        drive_pc(D_LG, 32'h14);
        for (int i = 0; i < 4; i++) begin
            drive_upd(D_LG, 1'b1, 4'h5, lg_t[i], lg_p[i]);
            expect_val(D_LG, F_INDEX, 5, $sformatf("lg_index_%0d", i));
            expect_val(D_LG, F_TAKEN, 32'(lg_p[i]), $sformatf("lg_taken_%0d", i));
            tick();
        end
        drive_upd(D_LG, 1'b0, 4'h0, 1'b0, 1'b0);
        expect_val(D_LG, F_TAKEN, 1, "lg_taken_final");
        expect_val(D_LG, F_NB_BRANCH, 4, "lg_nb_branch");
        expect_val(D_LG, F_NB_HIT, 1, "lg_nb_hit");
        tick();

        tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
